dqs_rx_scan: RTL and testbench



---
 rtl/dqs_rx_scan.sv | 187 ++++++++++++++++++
 tb/tb_dqs_rx_scan.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dqs_rx_scan.sv
// rtl/dqs_rx_scan.sv - DQS receive IDELAY tap sweep, first pass-window search and centre reload
// Optional per-tap histogram outputs enabled by defining DQS_SCAN_DBG_EN.
module dqs_rx_scan #(
    parameter logic [7:0] DLY_MIN       = 8'd0,
    parameter logic [7:0] DLY_MAX       = 8'd31,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         SAMPLE_LOG2   = 3,
    parameter logic [3:0] EXPECT        = 4'b0101
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 dly_ready,
    input  logic [3:0]           dqs_samples,
    output logic                 ld_dly,
    output logic [7:0]           dly,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic                 err,
    output logic [7:0]           win_first,
    output logic [7:0]           win_last,
    output logic [7:0]           dly_center
`ifdef DQS_SCAN_DBG_EN
    ,
    output logic                 dbg_valid,
    output logic [7:0]           dbg_tap,
    output logic [SAMPLE_LOG2:0] dbg_count
`endif
);
    localparam int             CW          = SAMPLE_LOG2 + 1;
    localparam logic [7:0]     SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]     SAMPLE_LAST = 8'((1 << SAMPLE_LOG2) - 1);
    localparam logic [CW-1:0]  HALF        = CW'(1 << (SAMPLE_LOG2 - 1));

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SAMPLE, EVAL, FINISH, DONE} state_t;

    state_t        state_q;
    logic [7:0]    tap_q, cnt_q;
    logic [CW-1:0] match_q, match_d;
    logic          in_win_q, in_win_d, pass_d, close_d;
    logic          ld_dly_q, busy_q, done_q, found_q, err_q;
    logic [7:0]    dly_q, win_first_q, win_last_q, dly_center_q;
    logic [7:0]    win_first_d, win_last_d, center_d;
    logic [8:0]    sum_d;
`ifdef DQS_SCAN_DBG_EN
    logic          dbg_valid_q;
    logic [7:0]    dbg_tap_q;
    logic [CW-1:0] dbg_count_q;
`endif

    // Window bookkeeping for the tap being evaluated; only meaningful in EVAL.
    always_comb begin
        match_d     = match_q + CW'(dqs_samples == EXPECT);
        pass_d      = match_q > HALF;
        in_win_d    = in_win_q | pass_d;
        win_first_d = win_first_q;
        win_last_d  = win_last_q;
        if (pass_d) begin
            if (!in_win_q) win_first_d = tap_q;
            win_last_d = tap_q;
        end
        close_d  = (!pass_d && in_win_q) || (tap_q == DLY_MAX);
        sum_d    = {1'b0, win_first_d} + {1'b0, win_last_d};
        center_d = 8'(sum_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            tap_q        <= '0;
            cnt_q        <= '0;
            match_q      <= '0;
            in_win_q     <= 1'b0;
            ld_dly_q     <= 1'b0;
            dly_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            err_q        <= 1'b0;
            win_first_q  <= '0;
            win_last_q   <= '0;
            dly_center_q <= '0;
`ifdef DQS_SCAN_DBG_EN
            dbg_valid_q  <= 1'b0;
            dbg_tap_q    <= '0;
            dbg_count_q  <= '0;
`endif
        end else begin
            ld_dly_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef DQS_SCAN_DBG_EN
            dbg_valid_q <= 1'b0;
`endif
            if (busy_q && !dly_ready) begin
                // Losing IDELAYCTRL ready invalidates every tap measured so far.
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
                found_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start && dly_ready) begin
                        state_q      <= LOAD;
                        tap_q        <= DLY_MIN;
                        busy_q       <= 1'b1;
                        found_q      <= 1'b0;
                        err_q        <= 1'b0;
                        in_win_q     <= 1'b0;
                        win_first_q  <= '0;
                        win_last_q   <= '0;
                        dly_center_q <= '0;
                        ld_dly_q     <= 1'b1;
                        dly_q        <= DLY_MIN;
                    end
                    LOAD: begin
                        state_q <= SETTLE;
                        cnt_q   <= '0;
                        match_q <= '0;
                    end
                    SETTLE: begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == SETTLE_LAST) begin
                            state_q <= SAMPLE;
                            cnt_q   <= '0;
                        end
                    end
                    SAMPLE: begin
                        match_q <= match_d;
                        cnt_q   <= cnt_q + 8'd1;
                        if (cnt_q == SAMPLE_LAST) begin
                            state_q <= EVAL;
`ifdef DQS_SCAN_DBG_EN
                            dbg_valid_q <= 1'b1;
                            dbg_tap_q   <= tap_q;
                            dbg_count_q <= match_d;
`endif
                        end
                    end
                    EVAL: begin
                        in_win_q    <= in_win_d;
                        win_first_q <= win_first_d;
                        win_last_q  <= win_last_d;
                        ld_dly_q    <= 1'b1;
                        if (close_d) begin
                            state_q <= FINISH;
                            found_q <= in_win_d;
                            if (in_win_d) begin
                                dly_center_q <= center_d;
                                dly_q        <= center_d;
                            end else begin
                                dly_q <= DLY_MIN;
                            end
                        end else begin
                            state_q <= LOAD;
                            tap_q   <= tap_q + 8'd1;
                            dly_q   <= tap_q + 8'd1;
                        end
                    end
                    FINISH: begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ld_dly     = ld_dly_q;
    assign dly        = dly_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign found      = found_q;
    assign err        = err_q;
    assign win_first  = win_first_q;
    assign win_last   = win_last_q;
    assign dly_center = dly_center_q;
`ifdef DQS_SCAN_DBG_EN
    assign dbg_valid  = dbg_valid_q;
    assign dbg_tap    = dbg_tap_q;
    assign dbg_count  = dbg_count_q;
`endif
endmodule

// File: tb/tb_dqs_rx_scan.sv
// tb/tb_dqs_rx_scan.sv - randomized self-checking bench for dqs_rx_scan against a window-search model
`timescale 1ns/1ps
module tb_dqs_rx_scan;
    localparam int         DMIN   = 0;
    localparam int         DMAX   = 31;
    localparam int         SETTLE = 4;
    localparam int         SLOG   = 3;
    localparam int         N      = 1 << SLOG;
    localparam int         TAPLAT = 1 + SETTLE + N + 1;
    localparam logic [3:0] EXP    = 4'b0101;

    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, dly_ready = 1'b1;
    logic [3:0] dqs_samples = 4'd0;
    logic       ld_dly, busy, done, found, err;
    logic [7:0] dly, win_first, win_last, dly_center;
`ifdef DQS_SCAN_DBG_EN
    logic        dbg_valid;
    logic [7:0]  dbg_tap;
    logic [SLOG:0] dbg_count;
`endif

    dqs_rx_scan #(.DLY_MIN(8'(DMIN)), .DLY_MAX(8'(DMAX)), .SETTLE_CYCLES(SETTLE),
                  .SAMPLE_LOG2(SLOG), .EXPECT(EXP)) dut (
        .clk(clk), .rst(rst), .start(start), .dly_ready(dly_ready), .dqs_samples(dqs_samples),
        .ld_dly(ld_dly), .dly(dly), .busy(busy), .done(done), .found(found), .err(err),
        .win_first(win_first), .win_last(win_last), .dly_center(dly_center)
`ifdef DQS_SCAN_DBG_EN
        , .dbg_valid(dbg_valid), .dbg_tap(dbg_tap), .dbg_count(dbg_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int m_tab[256];
    int rot[256];
    int cur_tap = 0, phase = 0, dbg_pulses = 0;
    int e_found, e_wf, e_wl, e_ctr, e_v, e_dly, e_lat;
    int o_found, o_wf, o_wl, o_ctr, o_err, o_busy, o_lat, o_dly, o_loads, o_timeout;

    // Delay-line model: the loaded tap decides how many of its sample words carry EXPECT.
    initial begin
        logic [3:0] nm;
        forever begin
            @(posedge clk); #1;
            if (ld_dly) begin cur_tap = int'(dly); phase = 0; end
            else phase++;
            if (phase >= 1 + SETTLE && phase < 1 + SETTLE + N &&
                ((phase - 1 - SETTLE + rot[cur_tap]) % N) < m_tab[cur_tap])
                dqs_samples = EXP;
            else begin
                nm = 4'($urandom_range(0, 15));
                if (nm == EXP) nm = ~EXP;
                dqs_samples = nm;
            end
`ifdef DQS_SCAN_DBG_EN
            if (dbg_valid) begin
                dbg_pulses++;
                n_cmp++;
                if (int'(dbg_tap) !== cur_tap || int'(dbg_count) !== m_tab[cur_tap]) begin
                    n_bad++;
                    $display("FAIL dbg_hist: tap %0d count %0d, want tap %0d count %0d", dbg_tap, dbg_count, cur_tap, m_tab[cur_tap]);
                end
            end
`endif
        end
    end

    task automatic set_table(input int lo, input int hi, input bit rnd);
        for (int t = 0; t < 256; t++) begin
            rot[t] = int'($urandom_range(0, N - 1));
            if (t >= lo && t <= hi) m_tab[t] = rnd ? int'($urandom_range(N / 2 + 1, N)) : N;
            else                    m_tab[t] = rnd ? int'($urandom_range(0, N / 2)) : 0;
        end
    endtask

    // Reference: first run of strict-majority taps, stop one tap after it ends.
    task automatic model();
        bit inw = 0;
        e_wf = 0; e_wl = 0; e_ctr = 0; e_v = 0;
        for (int t = DMIN; t <= DMAX; t++) begin
            e_v++;
            if (2 * m_tab[t] > N) begin
                if (!inw) e_wf = t;
                inw = 1;
                e_wl = t;
            end else if (inw) break;
        end
        e_found = inw;
        if (inw) e_ctr = (e_wf + e_wl) / 2;
        e_dly = inw ? e_ctr : DMIN;
        e_lat = TAPLAT * e_v + 2;
    endtask

    task automatic run_scan(input int inj);
        o_loads = 0; o_timeout = 1; o_lat = 0; o_dly = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 3000; k++) begin
            if (ld_dly) begin o_loads++; o_dly = int'(dly); end
            start = (k == inj);
            if (done) begin
                o_found = found; o_wf = win_first; o_wl = win_last; o_ctr = dly_center;
                o_err = err; o_busy = busy; o_lat = k; o_timeout = 0;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({ld_dly, dly, busy, done, found, err, win_first, win_last, dly_center} !== 45'd0) begin
            n_bad++; $display("FAIL reset_state: got %h want 0", {ld_dly, dly, busy, done, found, err, win_first, win_last, dly_center});
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_window();
        set_table(10, 17, 0); model(); run_scan(0);
        n_cmp++; if (o_timeout !== 0) begin n_bad++; $display("FAIL win_done: no done pulse"); end
        n_cmp++; if (o_found !== 1 || o_wf !== 10 || o_wl !== 17) begin n_bad++; $display("FAIL win_bounds: found %0d %0d..%0d want 1 10..17", o_found, o_wf, o_wl); end
        n_cmp++; if (o_ctr !== 13 || o_dly !== 13) begin n_bad++; $display("FAIL win_center: center %0d reload %0d want 13", o_ctr, o_dly); end
        n_cmp++; if (o_err !== 0) begin n_bad++; $display("FAIL win_err: got %0d want 0", o_err); end
        n_cmp++; if (o_lat !== e_lat) begin n_bad++; $display("FAIL win_latency: got %0d want %0d", o_lat, e_lat); end
    endtask

    task automatic test_no_match();
        set_table(1, 0, 0); run_scan(0);
        n_cmp++; if (o_found !== 0 || o_wf !== 0 || o_wl !== 0 || o_ctr !== 0) begin n_bad++; $display("FAIL nomatch_result: found %0d win %0d..%0d ctr %0d want all 0", o_found, o_wf, o_wl, o_ctr); end
        n_cmp++; if (o_dly !== DMIN || o_loads !== 33) begin n_bad++; $display("FAIL nomatch_loads: reload %0d loads %0d want 0/33", o_dly, o_loads); end
        n_cmp++; if (o_lat !== 32 * TAPLAT + 2) begin n_bad++; $display("FAIL nomatch_latency: got %0d want %0d", o_lat, 32 * TAPLAT + 2); end
    endtask

    task automatic test_edges();
        set_table(28, 31, 0); run_scan(0);
        n_cmp++; if (o_wf !== 28 || o_wl !== 31 || o_ctr !== 29 || o_found !== 1) begin n_bad++; $display("FAIL top_edge: %0d..%0d ctr %0d want 28..31 ctr 29", o_wf, o_wl, o_ctr); end
        n_cmp++; if (o_lat !== 32 * TAPLAT + 2) begin n_bad++; $display("FAIL top_latency: got %0d want %0d", o_lat, 32 * TAPLAT + 2); end
        set_table(3, 5, 0);
        for (int t = 20; t <= 25; t++) m_tab[t] = N;
        run_scan(0);
        n_cmp++; if (o_wf !== 3 || o_wl !== 5 || o_ctr !== 4) begin n_bad++; $display("FAIL two_win: %0d..%0d ctr %0d want 3..5 ctr 4", o_wf, o_wl, o_ctr); end
        n_cmp++; if (o_loads !== 8 || o_lat !== 7 * TAPLAT + 2) begin n_bad++; $display("FAIL two_win_stop: loads %0d lat %0d want 8/%0d", o_loads, o_lat, 7 * TAPLAT + 2); end
    endtask

    task automatic test_majority();
        set_table(6, 31, 0);
        m_tab[5] = N / 2;
        for (int t = 6; t <= 31; t++) m_tab[t] = N / 2 + 1;
        run_scan(0);
        n_cmp++; if (o_found !== 1 || o_wf !== 6 || o_wl !== 31 || o_ctr !== 18) begin n_bad++; $display("FAIL majority: found %0d %0d..%0d ctr %0d want 1 6..31 ctr 18", o_found, o_wf, o_wl, o_ctr); end
    endtask

    task automatic test_random();
        int lo, hi;
        for (int it = 0; it < 8; it++) begin
            lo = int'($urandom_range(0, 31));
            hi = int'($urandom_range(0, 4)) == 0 ? lo - 1 : int'($urandom_range(lo, 31));
            set_table(lo, hi, 1);
            if (hi + 3 <= 31) m_tab[hi + 2 + int'($urandom_range(0, 31 - hi - 2))] = N;
            model(); run_scan(0);
            n_cmp++;
            if (o_timeout !== 0 || o_found !== e_found || o_wf !== e_wf || o_wl !== e_wl || o_ctr !== e_ctr ||
                o_dly !== e_dly || o_lat !== e_lat || o_loads !== e_v + 1 || o_busy !== 0 || o_err !== 0) begin
                n_bad++;
                $display("FAIL random_%0d: found %0d win %0d..%0d ctr %0d dly %0d lat %0d loads %0d busy %0d; want %0d %0d..%0d %0d %0d %0d %0d 0",
                         it, o_found, o_wf, o_wl, o_ctr, o_dly, o_lat, o_loads, o_busy, e_found, e_wf, e_wl, e_ctr, e_dly, e_lat, e_v + 1);
            end
        end
    endtask

    task automatic test_start_ignored();
        int lds = 0;
        set_table(12, 20, 1); model(); run_scan(40);
        n_cmp++; if (o_lat !== e_lat || o_wf !== e_wf || o_wl !== e_wl) begin n_bad++; $display("FAIL start_busy: lat %0d win %0d..%0d want %0d %0d..%0d", o_lat, o_wf, o_wl, e_lat, e_wf, e_wl); end
        dly_ready = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (ld_dly || busy) lds++;
            @(posedge clk); #1;
        end
        dly_ready = 1'b1;
        n_cmp++; if (lds !== 0) begin n_bad++; $display("FAIL start_not_ready: %0d active cycles want 0", lds); end
    endtask

    task automatic test_abort();
        bit got = 0;
        set_table(10, 17, 0);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < 500 && !got; k++) begin
            if (ld_dly && dly == 8'd7) got = 1;
            else begin @(posedge clk); #1; end
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL abort_reach: tap 7 load not seen"); end
        repeat (5) @(posedge clk);
        #1; dly_ready = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({busy, done, err, found, ld_dly} !== 5'b01100) begin n_bad++; $display("FAIL abort_pulse: busy/done/err/found/ld %b want 01100", {busy, done, err, found, ld_dly}); end
        dly_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if ({busy, done, err} !== 3'b001) begin n_bad++; $display("FAIL abort_hold: busy/done/err %b want 001", {busy, done, err}); end
        model(); run_scan(0);
        n_cmp++; if (o_err !== 0 || o_ctr !== 13) begin n_bad++; $display("FAIL abort_recover: err %0d ctr %0d want 0/13", o_err, o_ctr); end
    endtask

    task automatic test_reset_mid();
        bit got = 0;
        int dn = 0;
        set_table(1, 5, 0);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < 500 && !got; k++) begin
            if (ld_dly && dly == 8'd3) got = 1;
            else begin @(posedge clk); #1; end
        end
        repeat (SETTLE + 3) @(posedge clk);
        #1;
        n_cmp++; if (!got || busy !== 1) begin n_bad++; $display("FAIL rstmid_reach: got %0d busy %0d want 1/1", got, busy); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({ld_dly, dly, busy, done, found, err, win_first, win_last, dly_center} !== 45'd0) begin
            n_bad++; $display("FAIL rstmid_clear: got %h want 0", {ld_dly, dly, busy, done, found, err, win_first, win_last, dly_center});
        end
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (done || busy) dn++;
            @(posedge clk); #1;
        end
        n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL rstmid_nodone: %0d active cycles want 0", dn); end
    endtask

`ifdef DQS_SCAN_DBG_EN
    task automatic test_dbg();
        int before;
        set_table(8, 14, 1); model();
        before = dbg_pulses;
        run_scan(0);
        n_cmp++; if (dbg_pulses - before !== e_v) begin n_bad++; $display("FAIL dbg_pulses: got %0d want %0d", dbg_pulses - before, e_v); end
    endtask
`endif

    initial begin
        for (int t = 0; t < 256; t++) begin m_tab[t] = 0; rot[t] = 0; end
        test_reset();
        test_window();
        test_no_match();
        test_edges();
        test_majority();
        test_random();
        test_start_ignored();
        test_abort();
        test_reset_mid();
`ifdef DQS_SCAN_DBG_EN
        test_dbg();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
